// File: rtl/xor_arb_pkg.sv
// Shared types and the lane-pick rule for the two-lane XOR arbiter.
package xor_arb_pkg;

    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_e;

    typedef logic lane_t;

    // A tie goes to the lane that was not served last; otherwise the lone requester wins.
    function automatic lane_t pick_lane(input logic [NUM_LANES-1:0] vld, input lane_t last);
        if (&vld)
            return ~last;
        else if (vld[1])
            return 1'b1;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/xor_lane_arbiter_xor_unit.sv
// Shared registered XOR datapath; the arbiter decides when it loads.
module xor_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] r_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_y <= '0;
        else if (en)
            r_y <= a ^ b;
    end

    assign y = r_y;

endmodule

// File: rtl/xor_lane_arbiter.sv
// Round-robin arbiter sharing one registered XOR unit between two request/response lanes.
module xor_lane_arbiter
    import xor_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_LANES-1:0] req_valid,
    output logic [NUM_LANES-1:0] req_ready,
    input  logic [WIDTH-1:0]     req_a0,
    input  logic [WIDTH-1:0]     req_b0,
    input  logic [WIDTH-1:0]     req_a1,
    input  logic [WIDTH-1:0]     req_b1,
    output logic [NUM_LANES-1:0] rsp_valid,
    input  logic [NUM_LANES-1:0] rsp_ready,
    output logic [WIDTH-1:0]     rsp_data0,
    output logic [WIDTH-1:0]     rsp_data1,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count
);

    state_e                            r_state, w_state_nxt;
    lane_t                             r_grant, r_last_grant, w_grant;
    logic [CNT_W-1:0]                  r_op_count;
    logic [NUM_LANES-1:0][WIDTH-1:0]   r_rsp_data;
    logic [NUM_LANES-1:0][WIDTH-1:0]   w_req_a, w_req_b;
    logic [WIDTH-1:0]                  w_y;
    logic                              w_accept, w_rsp_hs;

    assign w_req_a  = {req_a1, req_a0};
    assign w_req_b  = {req_b1, req_b0};
    assign w_grant  = pick_lane(req_valid, r_last_grant);
    assign w_accept = (r_state == IDLE) && (|req_valid);
    // Response handshake only looks at the granted lane's ready.
    assign w_rsp_hs = (r_state == RESPOND) && rsp_ready[r_grant];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = COMPUTE;
            COMPUTE: w_state_nxt = RESPOND;
            RESPOND: if (w_rsp_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_op_count   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept)
                r_grant <= w_grant;
            if (w_rsp_hs) begin
                r_last_grant <= r_grant;
                r_op_count   <= r_op_count + CNT_W'(1);
            end
        end
    end

    xor_unit #(.WIDTH(WIDTH)) u_xor (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_accept),
        .a     (w_req_a[w_grant]),
        .b     (w_req_b[w_grant]),
        .y     (w_y)
    );

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        // Each lane's result register only moves when that lane owns the unit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_rsp_data[i] <= '0;
            else if ((r_state == COMPUTE) && (r_grant == lane_t'(i)))
                r_rsp_data[i] <= w_y;
        end

        assign req_ready[i] = w_accept && (w_grant == lane_t'(i));
        assign rsp_valid[i] = (r_state == RESPOND) && (r_grant == lane_t'(i));
    end

    assign rsp_data0 = r_rsp_data[0];
    assign rsp_data1 = r_rsp_data[1];
    assign busy      = (r_state != IDLE);
    assign op_count  = r_op_count;

endmodule

// File: doc/xor_lane_arbiter.md
# xor_lane_arbiter

Round-robin controller that shares one registered XOR datapath between two requester lanes. Each lane presents an operand pair over a valid/ready request channel and receives the XOR result over its own valid/ready response channel. Sits between lane-level logic and the single shared XOR unit, so designs stop instantiating one XOR per lane. One operation is in flight at a time; fairness is strict alternation under contention.

## Interface
- WIDTH, 8, operand and result width in bits
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  2  per-lane request valid, bit i = lane i
- req_ready  out  2  per-lane request accept, one-hot or zero
- req_a0, req_b0  in  WIDTH  lane 0 operands
- req_a1, req_b1  in  WIDTH  lane 1 operands
- rsp_valid  out  2  per-lane response valid, one-hot or zero
- rsp_ready  in  2  per-lane response accept
- rsp_data0, rsp_data1  out  WIDTH  per-lane result, holds last result for that lane
- busy  out  1  high whenever state is not IDLE
- op_count  out  CNT_W  completed response handshakes, wraps

## Operation
- States: IDLE, COMPUTE, RESPOND. Reset state is IDLE.
- IDLE: if any req_valid is high, the arbiter picks a lane.
  - One requester: that lane.
  - Both: the lane not equal to last_grant.
  - req_ready[grant] is high the same cycle, combinationally from req_valid, state and last_grant.
  - The unit captures operands into xor_unit and goes to COMPUTE. With no request it stays in IDLE and req_ready = 0.
- COMPUTE: xor_unit registers a XOR b. The unit loads rsp_data<grant> and goes to RESPOND.
- RESPOND:
  - rsp_valid[grant] = 1. rsp_data<grant> is stable.
  - On rsp_ready[grant] it goes to IDLE, sets last_grant to grant, and increments op_count modulo 2^CNT_W.
  - rsp_ready of the non-granted lane is ignored.
- req_ready is 0 in COMPUTE and RESPOND, so new requests wait. Requesters must hold req_valid and operands until accepted.
- Operands are sampled only on the accept cycle. Changes after acceptance have no effect.
- The data bus of the non-granted lane never changes.
- Reset values: req_ready = 0, rsp_valid = 0, rsp_data0 = rsp_data1 = 0, busy = 0, op_count = 0, last_grant = 1 (lane 0 wins the first tie).
- Reset asserted mid-operation: the in-flight operation is discarded and no response is produced. After release, operation resumes from IDLE with the reset priority.
- Simultaneous requests on the release cycle follow normal IDLE arbitration.

## Timing
- Accept at cycle N (req_valid & req_ready) gives rsp_valid high from cycle N+2 until the response handshake.
- Minimum issue interval is 3 cycles (accept, compute, respond with rsp_ready already high).
- Next accept is possible on the cycle after the response handshake.
- busy rises the cycle after accept and falls the cycle after the response handshake.
- op_count updates the cycle after the response handshake.
- Combinational paths: req_valid → req_ready only. No path from rsp_ready to any output within the same cycle, except the registered state change.

## Structure
- Package xor_arb_pkg:
  - NUM_LANES = 2
  - state_e enum {IDLE, COMPUTE, RESPOND}
  - lane_t, 1-bit lane index
- Sub-module xor_unit:
  - Parameter WIDTH.
  - Ports: clk, rst_n, en, a, b, y.
  - y is registered, loads a ^ b when en, resets to 0.
  - Holds the shared datapath. The arbiter owns all sequencing and the per-lane result registers.

## Test plan
- Single request: lane 0, a = 8'hA5, b = 8'h0F, rsp_ready held high.
  - Required: req_ready[0] high at cycle N; rsp_valid[0] high at N+2 with rsp_data0 = 8'hAA; op_count = 1 after the handshake.
  - rsp_data1 stays 0.
- Tie after reset: both lanes request together (lane 0 8'hFF^8'h01, lane 1 8'h3C^8'h3C).
  - Required: lane 0 served first (rsp_data0 = 8'hFE), then lane 1 (rsp_data1 = 8'h00).
  - Second accept occurs 3 cycles after the first.
- Continuous contention, 10 operations: grants strictly alternate 0,1,0,1…; op_count = 10.
- Backpressure: rsp_ready[1] held low 5 cycles during lane 1 RESPOND while lane 0 requests.
  - Required: rsp_valid[1] and rsp_data1 stable; req_ready[0] = 0 throughout.
  - Lane 0 is accepted the cycle after the lane 1 handshake.
  - rsp_ready[0] pulsed during this window is ignored.
- Reset in COMPUTE: assert rst_n low asynchronously mid-cycle.
  - Required: all outputs reach reset values immediately; no rsp_valid after release.
  - A lane 1 request after release completes normally.
- Counter wrap: preload op_count to 16'hFFFF by force, complete one operation → op_count = 16'h0000.
